mac_operand_feeder: RTL and testbench
=====================================

# mac_operand_feeder

Upstream stage of the MAC datapath. Buffers 4-bit operand pairs in a small FIFO and issues them one at a time to the MAC's `A`/`B`/`go` inputs. It waits for the MAC's `done` pulse before issuing the next pair. A vector of `len` pairs is run per `start` command, and completion is reported with a one-cycle `vec_done` pulse.

## Interface
Parameters:
- `DW`, 4, operand width; matches MAC `A`/`B`.
- `DEPTH`, 8, FIFO depth in pairs; power of two, ≥2.
- `AW`, log2(DEPTH), FIFO pointer width; derived, not overridden.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  producer offers a pair.
- `in_a`  in  DW  operand A of the offered pair.
- `in_b`  in  DW  operand B of the offered pair.
- `in_ready`  out  1  FIFO not full; pair accepted when `in_valid && in_ready`.
- `start`  in  1  begin a vector; sampled only in IDLE.
- `len`  in  4  pairs in the vector; sampled with `start`.
- `abort`  in  1  synchronous return to IDLE.
- `A`  out  DW  operand to MAC.
- `B`  out  DW  operand to MAC.
- `go`  out  1  one-cycle issue strobe to MAC.
- `mac_done`  in  1  MAC completion pulse.
- `busy`  out  1  state ≠ IDLE.
- `vec_done`  out  1  one-cycle pulse when a vector completes.
- `issued`  out  4  pairs issued in the current vector.
- `level`  out  AW+1  FIFO occupancy, 0..DEPTH.

## Operation
- FIFO: circular buffer with AW+1-bit read/write pointers, wrapping modulo DEPTH.
  - Full when the pointers differ only in the MSB; empty when equal.
  - `in_ready = !full` (combinational from registered pointers).
  - Push and pop in the same cycle are both honoured; `level` is unchanged.
  - When full, a push is refused even if a pop occurs that cycle.
  - When empty, a same-cycle push is not visible to the pop.
- FSM states: IDLE, LOAD, ISSUE, WAIT, FINISH.
  - IDLE: on `start`, latch `len` and clear `issued`.
    - `len`=0 → FINISH.
    - `len`≠0 → LOAD.
  - LOAD: if the FIFO is non-empty, pop the head into the `A`/`B` registers and go to ISSUE. If empty, stall in LOAD with no timeout.
  - ISSUE: `go`=1 for exactly this cycle; `issued`+1; → WAIT.
  - WAIT: on `mac_done`, go to FINISH if `issued==len_latched`, else LOAD.
  - FINISH: `vec_done`=1 for one cycle; → IDLE.
- `mac_done` outside WAIT is ignored.
- `start` outside IDLE is ignored.
- `abort` in any state → IDLE next cycle.
  - `go` is not asserted in the abort cycle.
  - `vec_done` is not pulsed.
  - FIFO contents and `A`/`B` are kept.
  - `abort` has priority over `start` and `mac_done`.
- `A`/`B` change only on a LOAD pop. They are stable from ISSUE through WAIT.
- `issued` holds its final value after FINISH until the next accepted `start`.

## Timing
- Reset (`rst`=0, asynchronous) sets every output as follows:
  - `A`=0, `B`=0, `go`=0, `vec_done`=0, `busy`=0, `issued`=0, `level`=0.
  - `in_ready`=1, FIFO empty, state IDLE.
- Reset mid-vector discards the FIFO contents and the vector.
- Deassertion takes effect at the next rising edge.
- Latency with data already queued: `start` sampled at edge k → LOAD in cycle k+1 → `go` high in cycle k+2.
- After `mac_done` sampled at edge m in WAIT:
  - next `go` in cycle m+2, if the FIFO is non-empty;
  - `vec_done` in cycle m+1, if this was the last pair.
- `len`=0: `vec_done` is high in the cycle after `start`; no `go`.
- All outputs are registered except `in_ready` and `busy`, which are decoded from registered state only.
- `level` updates in the cycle after the push or pop.

## Test plan
- Reset, then push (3,7),(12,6),(15,15) and `start` with `len`=3. A MAC model returns `mac_done` 4 cycles after each `go`. Required response:
  - exactly 3 `go` pulses, with `A`/`B` = (3,7), (12,6), (15,15);
  - `issued`=3, then a single `vec_done`, then `busy`=0, `level`=0.
- Push 8 pairs with no `start`. Required: `level`=8 and `in_ready`=0. A 9th `in_valid` is dropped, and `level` stays 8.
- `start` with `len`=2 on an empty FIFO. Required: the FSM stalls in LOAD with no `go`. Push (5,11); then `go` fires 2 cycles after the push and `A`=5, `B`=11.
- Full FIFO while the FSM pops in LOAD and `in_valid`=1 in the same cycle. Required: the push is refused and `level` goes from 8 to 7. With a non-full FIFO, simultaneous push and pop keep `level` constant.
- `abort` during WAIT of pair 2 of 4. Required:
  - `busy`=0 next cycle, no `vec_done`, and `mac_done` arriving after the abort is ignored;
  - a new `start` with `len`=1 issues the next queued pair.
- `rst` asserted asynchronously mid-ISSUE. Required: `go` drops immediately, all outputs take their reset values, and `level`=0.

Source files
------------

// File: rtl/mac_operand_feeder.sv
// mac_operand_feeder: buffers operand pairs in a FIFO and issues them one at a time to a MAC
//   clk, rst (async, active-low)
//   in_valid/in_a/in_b/in_ready : producer side, pair accepted on in_valid && in_ready
//   start/len/abort             : vector command (len pairs), abort returns to IDLE
//   A/B/go, mac_done            : MAC side, one go per pair, next pair only after mac_done
//   busy, vec_done, issued, level : status
module mac_operand_feeder #(
  parameter int DW = 4,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  output logic          in_ready,
  input  logic          start,
  input  logic [3:0]    len,
  input  logic          abort,
  output logic [DW-1:0] A,
  output logic [DW-1:0] B,
  output logic          go,
  input  logic          mac_done,
  output logic          busy,
  output logic          vec_done,
  output logic [3:0]    issued,
  output logic [AW:0]   level
);
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, FINISH} state_t;
  state_t state, nxt;
  logic [2*DW-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic [3:0] len_l;
  logic full, empty, push, pop;
  // pointers carry one extra wrap bit: equal means empty, differing only in the MSB means full
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign empty = wp == rp;
  assign in_ready = !full;
  assign busy = state != IDLE;
  assign push = in_valid && !full;
  // an abort in LOAD leaves the head pair queued
  assign pop = state == LOAD && !empty && !abort;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (len == 4'd0 ? FINISH : LOAD) : IDLE;
      LOAD:    nxt = empty ? LOAD : ISSUE;
      ISSUE:   nxt = WAIT;
      WAIT:    nxt = mac_done ? (issued == len_l ? FINISH : LOAD) : WAIT;
      default: nxt = IDLE;
    endcase
    if (abort) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= {in_a, in_b};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      level <= '0;
      A <= '0;
      B <= '0;
      go <= 1'b0;
      vec_done <= 1'b0;
      issued <= '0;
      len_l <= '0;
    end else begin
      state <= nxt;
      // go and vec_done are registered copies of the state being entered
      go <= nxt == ISSUE;
      vec_done <= nxt == FINISH;
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        {A, B} <= mem[rp[AW-1:0]];
        rp <= rp + 1'b1;
      end
      if (state == IDLE && start && !abort) begin
        len_l <= len;
        issued <= '0;
      end
      if (state == ISSUE) issued <= issued + 4'd1;
    end
  end
endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb_mac_operand_feeder: scoreboard bench for mac_operand_feeder with a delayed-done MAC model
module tb_mac_operand_feeder;
  localparam int DW = 4;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  logic clk = 0, rst = 0, in_valid = 0, start = 0, abort = 0, mac_done = 0;
  logic [DW-1:0] in_a = 0, in_b = 0;
  logic [3:0] len = 0;
  logic in_ready, go, busy, vec_done;
  logic [DW-1:0] A, B;
  logic [3:0] issued;
  logic [AW:0] level;
  int total = 0, bad = 0, exp_vd = 0, lvl = 0;
  logic [7:0] exp_q [$];

  mac_operand_feeder #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .start(start), .len(len), .abort(abort), .A(A), .B(B), .go(go), .mac_done(mac_done),
    .busy(busy), .vec_done(vec_done), .issued(issued), .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, want, $time);
    end
  endtask

  // MAC model: done pulse 4 cycles after each go
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      mac_done = 0;
      if (!rst) cnt = 0;
      else if (go) cnt = 4;
      else if (cnt != 0) begin
        cnt--;
        if (cnt == 0) mac_done = 1;
      end
    end
  end

  // monitor: every go must carry the oldest accepted, not yet issued pair
  always @(negedge clk) begin
    logic [7:0] p;
    if (rst) begin
      if (go) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL go_extra: got go with A=%0d B=%0d, expected no go", A, B);
        end else begin
          p = exp_q.pop_front();
          chk("go_A", A, p[7:4]);
          chk("go_B", B, p[3:0]);
        end
      end
      if (vec_done) begin
        total++;
        if (exp_vd == 0) begin
          bad++;
          $display("FAIL vec_done_extra: got vec_done=1, expected 0 at %0t", $time);
        end else exp_vd--;
      end
    end
  end

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    chk("in_ready", in_ready, lvl < DEPTH);
    in_valid = 1;
    in_a = a;
    in_b = b;
    if (lvl < DEPTH) begin
      exp_q.push_back({a, b});
      lvl++;
    end
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic run(input int l);
    start = 1;
    len = 4'(l);
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_vd(input string n);
    for (int i = 0; i < 300 && !vec_done; i++) @(negedge clk);
    if (!vec_done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got vec_done=0, expected 1 within 300 cycles", n);
    end
  endtask

  task automatic wait_go(input string n);
    for (int i = 0; i < 100 && !go; i++) @(negedge clk);
    if (!go) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got go=0, expected 1 within 100 cycles", n);
    end
  endtask

  initial begin
    int ng, l, k;
    logic [7:0] p2;
    repeat (2) @(negedge clk);
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_go", go, 0);
    chk("rst_vec_done", vec_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_issued", issued, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1;
    @(negedge clk);
    // basic vector of three
    push(3, 7);
    push(12, 6);
    push(15, 15);
    exp_vd++;
    run(3);
    wait_vd("basic");
    chk("basic_issued", issued, 3);
    lvl -= 3;
    @(negedge clk);
    chk("basic_busy", busy, 0);
    chk("basic_level", level, 0);
    // fill to full, ninth push dropped
    for (int i = 0; i < 8; i++) push(4'($urandom), 4'($urandom));
    chk("full_level", level, 8);
    chk("full_in_ready", in_ready, 0);
    push(4'd9, 4'd9);
    chk("full_level_after_drop", level, 8);
    // push refused while full even though LOAD pops the same cycle
    exp_vd++;
    run(2);
    chk("full_ready_in_load", in_ready, 0);
    in_valid = 1;
    in_a = 1;
    in_b = 1;
    @(negedge clk);
    in_valid = 0;
    chk("full_pop_level", level, 7);
    for (int i = 0; i < 50 && !mac_done; i++) @(negedge clk);
    chk("mac_done_seen", mac_done, 1);
    @(negedge clk);
    chk("pushpop_ready", in_ready, 1);
    in_valid = 1;
    in_a = 4'($urandom);
    in_b = 4'($urandom);
    exp_q.push_back({in_a, in_b});
    lvl++;
    @(negedge clk);
    in_valid = 0;
    chk("pushpop_level", level, 7);
    wait_vd("pushpop");
    lvl -= 2;
    @(negedge clk);
    // abort during WAIT of pair 2 of 4
    p2 = exp_q[1];
    run(4);
    ng = 0;
    for (int i = 0; i < 100 && ng < 2; i++) begin
      if (go) ng++;
      if (ng < 2) @(negedge clk);
    end
    chk("abort_two_gos", ng, 2);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_A_kept", A, p2[7:4]);
    chk("abort_B_kept", B, p2[3:0]);
    lvl -= 2;
    ng = 0;
    repeat (6) begin
      @(negedge clk);
      if (go || busy) ng++;
    end
    chk("abort_quiet", ng, 0);
    exp_vd++;
    run(1);
    wait_vd("after_abort");
    chk("after_abort_issued", issued, 1);
    lvl -= 1;
    @(negedge clk);
    exp_vd++;
    run(lvl);
    wait_vd("drain");
    lvl = 0;
    @(negedge clk);
    chk("drain_level", level, 0);
    // stall in LOAD on an empty FIFO
    exp_vd++;
    run(2);
    ng = 0;
    repeat (6) begin
      if (go) ng++;
      @(negedge clk);
    end
    chk("stall_no_go", ng, 0);
    chk("stall_busy", busy, 1);
    push(5, 11);
    chk("stall_go_early", go, 0);
    @(negedge clk);
    chk("stall_go", go, 1);
    chk("stall_A", A, 5);
    chk("stall_B", B, 11);
    push(4'($urandom), 4'($urandom));
    wait_vd("stall");
    lvl -= 2;
    @(negedge clk);
    // random vectors
    repeat (20) begin
      k = $urandom_range(0, 10);
      repeat (k) begin
        if ($urandom % 4 != 0) push(4'($urandom), 4'($urandom));
        else @(negedge clk);
      end
      chk("rnd_level", level, lvl);
      l = $urandom_range(0, lvl);
      exp_vd++;
      run(l);
      wait_vd("rnd");
      chk("rnd_issued", issued, l);
      lvl -= l;
      @(negedge clk);
      chk("rnd_level_after", level, lvl);
      chk("rnd_busy", busy, 0);
    end
    if (lvl != 0) begin
      exp_vd++;
      run(lvl);
      wait_vd("rnd_drain");
      lvl = 0;
      @(negedge clk);
    end
    // asynchronous reset in the middle of ISSUE
    push(4'($urandom), 4'($urandom));
    push(4'($urandom), 4'($urandom));
    run(2);
    wait_go("pre_reset");
    #1 rst = 0;
    #1;
    chk("areset_go", go, 0);
    chk("areset_A", A, 0);
    chk("areset_B", B, 0);
    chk("areset_busy", busy, 0);
    chk("areset_issued", issued, 0);
    chk("areset_level", level, 0);
    chk("areset_in_ready", in_ready, 1);
    chk("areset_vec_done", vec_done, 0);
    exp_q.delete();
    lvl = 0;
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    push(2, 3);
    exp_vd++;
    run(1);
    wait_vd("post_reset");
    @(negedge clk);
    chk("end_pending_vec_done", exp_vd, 0);
    chk("end_pending_pairs", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
